// File: rtl/stack_dump.sv
// stack_dump: mirrors a RAM-based Forth stack pointer/depth from snooped controls
// and, while the core is halted, streams the stack top-to-bottom over valid/ready.
module stack_dump #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [1:0]            delta,
    input  logic                  halted,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [WIDTH-1:0]      ram_rdata,
    output logic [WIDTH-1:0]      dump_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic                  dump_last,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  ovf,
    output logic                  unf
);
    typedef enum logic [1:0] {IDLE, RD, WT, SEND} state_t;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d, ram_addr_q;
    logic [ADDR_WIDTH:0]   depth_q, depth_d, cnt_q, cnt_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;
    logic                  push, pop, full, empty, hs;

    always_comb begin
        push       = we & (delta == 2'b01);
        pop        = ~we & (delta == 2'b11);
        full       = depth_q == FULL;
        empty      = depth_q == '0;
        ptr_d      = push ? ptr_q + 1'b1 : pop ? ptr_q - 1'b1 : ptr_q;
        depth_d    = (push & ~full) ? depth_q + 1'b1 : (pop & ~empty) ? depth_q - 1'b1 : depth_q;
        ovf_d      = ovf_q | (push & full);
        unf_d      = unf_q | (pop & empty);
        busy       = state_q != IDLE;
        aborted    = busy & ~halted;
        // losing halt kills the offer immediately so no handshake can land
        dump_valid = (state_q == SEND) & halted;
        dump_last  = dump_valid & (cnt_q == ONE);
        hs         = dump_valid & dump_ready;
        done       = done_q | (hs & (cnt_q == ONE));
        done_d     = (state_q == IDLE) & start & halted & empty;
        ram_addr   = (state_q == RD) ? addr_q : ram_addr_q;
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        if (aborted) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start & halted & ~empty) begin
                    state_d = RD;
                    addr_d  = ptr_q;
                    cnt_d   = depth_q;
                end
                RD:   state_d = WT;
                WT: begin
                    state_d = SEND;
                    data_d  = ram_rdata;
                end
                SEND: if (hs) begin
                    state_d = (cnt_q == ONE) ? IDLE : RD;
                    addr_d  = addr_q - 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            ram_addr_q <= '0;
            depth_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            ram_addr_q <= ram_addr;
            depth_q    <= depth_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            done_q     <= done_d;
        end
    end

    assign dump_data = data_q;
    assign depth     = depth_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
endmodule

// File: tb/tb_stack_dump.sv
// tb_stack_dump: randomized bench for stack_dump (DEPTH=8) against a queue/array
// model of the stack and the RAM behind it.
module tb_stack_dump;
    logic        clk, rst_n, we, halted, start, dump_ready;
    logic [1:0]  delta;
    logic [2:0]  ram_addr;
    logic [15:0] ram_rdata, dump_data;
    logic        dump_valid, dump_last, busy, done, aborted, ovf, unf;
    logic [3:0]  depth;

    logic [15:0] mem [8];
    int m_ptr, m_depth;
    bit m_ovf, m_unf;
    int vectors = 0;
    int errors  = 0;

    stack_dump #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .delta(delta), .halted(halted),
        .start(start), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_last(dump_last), .busy(busy), .done(done), .aborted(aborted),
        .depth(depth), .ovf(ovf), .unf(unf)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    task automatic model_reset();
        m_ptr = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; we = 0; delta = 0; start = 0; dump_ready = 0; halted = 1;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic snoop(input logic w, input logic [1:0] d);
        logic [15:0] v;
        v = 16'($urandom);
        @(negedge clk);
        we = w; delta = d;
        if (w && d == 2'b01) begin
            m_ptr = (m_ptr + 1) % 8;
            mem[m_ptr] = v;
            if (m_depth == 8) m_ovf = 1; else m_depth++;
        end else if (!w && d == 2'b11) begin
            m_ptr = (m_ptr + 7) % 8;
            if (m_depth == 0) m_unf = 1; else m_depth--;
        end
        @(negedge clk);
        we = 0; delta = 0;
        #1;
        vectors++;
        if (depth !== 4'(m_depth)) begin errors++; $display("FAIL snoop_depth got %0d want %0d", depth, m_depth); end
        vectors++;
        if ({ovf, unf} !== {m_ovf, m_unf}) begin errors++; $display("FAIL snoop_flags ovf/unf got %b%b want %b%b", ovf, unf, m_ovf, m_unf); end
    endtask

    task automatic random_snoop();
        int r;
        r = $urandom_range(0, 5);
        if (r <= 2) snoop(1, 2'b01);
        else if (r == 3) snoop(0, 2'b11);
        else if (r == 4) snoop(1, 2'b11);
        else snoop(0, 2'($urandom_range(0, 2)));
    endtask

    // mode 0: ready always high; 1: random ready and stray starts; 2: ready low until cycle 8
    task automatic run_dump(input int mode);
        logic [2:0]  ea[$];
        logic [15:0] ed[$];
        logic [15:0] prev_d;
        int n, idx, first, dc;
        bit prev_stall, fin;
        n = m_depth;
        for (int i = 0; i < n; i++) begin
            ea.push_back(3'((m_ptr - i + 8) % 8));
            ed.push_back(mem[(m_ptr - i + 8) % 8]);
        end
        @(negedge clk);
        start = 1; dump_ready = 0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL dump_pre_busy got %b want 0", busy); end
        idx = 0; first = -1; dc = -1; prev_stall = 0; fin = 0; prev_d = '0;
        for (int c = 1; c <= 400 && !fin; c++) begin
            @(negedge clk);
            start = (mode == 1 && n > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            dump_ready = (mode == 0) ? 1'b1 : (mode == 2) ? (c >= 8) : 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                vectors++;
                if (dump_valid !== 1'b1 || dump_data !== prev_d) begin
                    errors++; $display("FAIL stall_hold got v=%b d=%h want v=1 d=%h", dump_valid, dump_data, prev_d);
                end
            end
            if (dump_valid === 1'b1) begin
                if (first < 0) first = c;
                vectors++;
                if (idx >= n) begin
                    errors++; $display("FAIL extra_beat got beat %0d want only %0d", idx, n);
                end else if (dump_data !== ed[idx] || ram_addr !== ea[idx] || dump_last !== (idx == n - 1)) begin
                    errors++;
                    $display("FAIL beat%0d got d=%h a=%0d l=%b want d=%h a=%0d l=%b", idx, dump_data, ram_addr, dump_last, ed[idx], ea[idx], idx == n - 1);
                end
                prev_stall = !dump_ready; prev_d = dump_data;
                if (dump_ready) idx++;
            end else prev_stall = 0;
            vectors++;
            if (busy !== (n > 0)) begin errors++; $display("FAIL dump_busy cycle %0d got %b want %b", c, busy, n > 0); end
            if (done === 1'b1) begin fin = 1; dc = c; end
        end
        vectors++;
        if (!fin) begin errors++; $display("FAIL dump_timeout got no done want done"); end
        vectors++;
        if (idx != n) begin errors++; $display("FAIL beat_count got %0d want %0d", idx, n); end
        if (mode == 0) begin
            vectors++;
            if (n > 0 && (first != 3 || dc != 3 * n)) begin
                errors++; $display("FAIL dump_timing got first=%0d done=%0d want 3 and %0d", first, dc, 3 * n);
            end else if (n == 0 && (first != -1 || dc != 1)) begin
                errors++; $display("FAIL empty_timing got first=%0d done=%0d want -1 and 1", first, dc);
            end
        end
        @(negedge clk);
        start = 0; dump_ready = 0;
        #1;
        vectors++;
        if ({busy, done, dump_valid} !== 3'b000) begin errors++; $display("FAIL post_dump got b/d/v=%b%b%b want 000", busy, done, dump_valid); end
    endtask

    task automatic test_reset();
        rst_n = 0; we = 0; delta = 0; start = 0; dump_ready = 0; halted = 1;
        model_reset();
        #1;
        vectors++;
        if ({ram_addr, dump_data, dump_valid, dump_last, busy, done, aborted, depth, ovf, unf} !== '0) begin
            errors++; $display("FAIL reset_outputs got depth=%0d busy=%b data=%h want all 0", depth, busy, dump_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        do_reset();
        repeat (3) snoop(1, 2'b01);
        run_dump(0);
        vectors++;
        if (depth !== 4'd3) begin errors++; $display("FAIL basic_depth got %0d want 3", depth); end
    endtask

    task automatic test_empty();
        do_reset();
        run_dump(0);
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (9) snoop(1, 2'b01);
        run_dump(0);
        repeat (9) snoop(0, 2'b11);
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) snoop(1, 2'b01);
        run_dump(2);
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (2) snoop(0, 2'b11);
        repeat (2) snoop(1, 2'b01);
        run_dump(0);
    endtask

    task automatic test_abort();
        bit seen;
        do_reset();
        repeat (4) snoop(1, 2'b01);
        @(negedge clk);
        start = 1; dump_ready = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            start = 0;
            #1;
            if (dump_valid === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin errors++; $display("FAIL abort_no_valid got none want valid"); end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        halted = 0;
        #1;
        vectors++;
        if ({aborted, dump_valid, done, busy} !== 4'b1001) begin
            errors++; $display("FAIL abort_pulse got a/v/d/b=%b%b%b%b want 1001", aborted, dump_valid, done, busy);
        end
        @(negedge clk);
        halted = 1;
        #1;
        vectors++;
        if ({aborted, dump_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL abort_after got a/v/b=%b%b%b want 000", aborted, dump_valid, busy);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({done, busy} !== 2'b00) begin errors++; $display("FAIL abort_quiet got d/b=%b%b want 00", done, busy); end
        end
        run_dump(0);
    endtask

    task automatic test_ignored_start();
        do_reset();
        repeat (2) snoop(1, 2'b01);
        @(negedge clk);
        halted = 0; start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({busy, done, dump_valid} !== 3'b000) begin errors++; $display("FAIL ignored_start got b/d/v=%b%b%b want 000", busy, done, dump_valid); end
        end
        halted = 1;
        run_dump(0);
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(2, 10)) random_snoop();
            run_dump(1);
        end
    endtask

    task automatic test_reset_mid_dump();
        do_reset();
        repeat (3) snoop(1, 2'b01);
        @(negedge clk);
        start = 1; dump_ready = 0;
        repeat (4) begin
            @(negedge clk);
            start = 0;
        end
        rst_n = 0;
        #1;
        vectors++;
        if ({busy, dump_valid, dump_data, ram_addr, depth, ovf, unf} !== '0) begin
            errors++; $display("FAIL reset_mid_dump got busy=%b depth=%0d data=%h want all 0", busy, depth, dump_data);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        run_dump(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_stall();
        test_wrap();
        test_abort();
        test_ignored_start();
        test_random();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
